// File: rtl/ysyx_22050710_pkg.sv
// ============================================================================
// Module   : ysyx_22050710_pkg
// Brief    : Shared widths, reset PC and state encodings for the PC unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_22050710_pkg;

    localparam int XLEN    = 64;
    localparam int INST_W  = 32;
    localparam int STATE_W = 3;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h8000_0000;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] S_EXEC  = 3'd3;
    localparam logic [STATE_W-1:0] S_HALT  = 3'd4;

    // No compressed instructions, so any nonzero low pair is a bad target.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22050710_reg.sv
// ============================================================================
// Module   : ysyx_22050710_reg
// Brief    : Generic register with write enable and async active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050710_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = i_en ? i_d : data_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_q = data_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_22050710_pcu.sv
// ============================================================================
// Module   : ysyx_22050710_pcu
// Brief    : PC ownership, fetch sequencing and retire/halt control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050710_pcu
    import ysyx_22050710_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_ifu_req_valid,
    input  logic              i_ifu_req_ready,
    output logic [XLEN-1:0]   o_ifu_addr,
    input  logic              i_ifu_rsp_valid,
    input  logic [INST_W-1:0] i_ifu_rsp_inst,
    output logic [XLEN-1:0]   o_pc,
    output logic [INST_W-1:0] o_inst,
    output logic              o_inst_valid,
    input  logic              i_exu_done,
    input  logic [XLEN-1:0]   i_dnpc,
    input  logic              i_halt,
    output logic              o_halted,
    output logic              o_fault,
    output logic [XLEN-1:0]   o_retire_cnt
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               fault_q;
    logic               fault_d;

    logic               w_pc_we;
    logic               w_inst_we;
    logic               w_retire;
    logic [XLEN-1:0]    w_retire_next;

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        w_pc_we   = 1'b0;
        w_inst_we = 1'b0;
        w_retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (i_ifu_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_ifu_rsp_valid) begin
                    w_inst_we = 1'b1;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                // ebreak outranks a bad target: the halting instruction still retires.
                if (i_exu_done) begin
                    if (i_halt) begin
                        w_retire = 1'b1;
                        state_d  = S_HALT;
                    end else if (is_misaligned(i_dnpc)) begin
                        fault_d  = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    assign w_retire_next = o_retire_cnt + 64'd1;

    ysyx_22050710_reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_pc_we),
        .i_d   (i_dnpc),
        .o_q   (o_pc)
    );

    ysyx_22050710_reg #(
        .WIDTH     (INST_W),
        .RESET_VAL ('0)
    ) u_inst_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_inst_we),
        .i_d   (i_ifu_rsp_inst),
        .o_q   (o_inst)
    );

    ysyx_22050710_reg #(
        .WIDTH     (XLEN),
        .RESET_VAL ('0)
    ) u_retire_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_retire),
        .i_d   (w_retire_next),
        .o_q   (o_retire_cnt)
    );

    // Every output is a register or a pure decode of state.
    assign o_ifu_req_valid = (state_q == S_FETCH);
    assign o_inst_valid    = (state_q == S_EXEC);
    assign o_halted        = (state_q == S_HALT);
    assign o_fault         = fault_q;
    assign o_ifu_addr      = o_pc;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050710_pcu.sv
// ============================================================================
// Module   : tb_ysyx_22050710_pcu
// Brief    : Directed plus randomized bench for the PC unit with a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22050710_pcu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] ifu_addr;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exu_done;
    logic [63:0] dnpc;
    logic        halt;
    logic        halted;
    logic        fault;
    logic [63:0] retire_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Architectural model: what the unit must expose, independent of encoding.
    logic [63:0] m_pc;
    logic [63:0] m_cnt;
    logic        m_halted;
    logic        m_fault;
    logic [31:0] m_inst;

    always #5 clk = ~clk;

    ysyx_22050710_pcu #(.RESET_PC(RST_PC)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .o_ifu_req_valid (req_valid),
        .i_ifu_req_ready (req_ready),
        .o_ifu_addr      (ifu_addr),
        .i_ifu_rsp_valid (rsp_valid),
        .i_ifu_rsp_inst  (rsp_inst),
        .o_pc            (pc),
        .o_inst          (inst),
        .o_inst_valid    (inst_valid),
        .i_exu_done      (exu_done),
        .i_dnpc          (dnpc),
        .i_halt          (halt),
        .o_halted        (halted),
        .o_fault         (fault),
        .o_retire_cnt    (retire_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_arch(input string tag);
        chk({tag, ".pc"},     pc,         m_pc);
        chk({tag, ".cnt"},    retire_cnt, m_cnt);
        chk({tag, ".halted"}, {63'd0, halted}, {63'd0, m_halted});
        chk({tag, ".fault"},  {63'd0, fault},  {63'd0, m_fault});
    endtask

    task automatic idle_inputs();
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_inst  = '0;
        exu_done  = 1'b0;
        dnpc      = '0;
        halt      = 1'b0;
    endtask

    task automatic model_reset();
        m_pc     = RST_PC;
        m_cnt    = '0;
        m_halted = 1'b0;
        m_fault  = 1'b0;
        m_inst   = '0;
    endtask

    // Reset asserted mid-cycle; returns at a negedge with the unit in FETCH.
    task automatic do_reset(input bit late_rsp);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_arch("rst");
        chk("rst.req_valid",  {63'd0, req_valid},  64'd0);
        chk("rst.inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst.inst",       {32'd0, inst},       64'd0);
        chk("rst.addr",       ifu_addr,            RST_PC);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        if (late_rsp) begin
            rsp_valid = 1'b1;
            rsp_inst  = 32'hdead_beef;
        end
        #1 chk("rst.idle_req", {63'd0, req_valid}, 64'd0);
        @(negedge clk);
        chk("rst.first_req", {63'd0, req_valid}, 64'd1);
        chk("rst.first_addr", ifu_addr, RST_PC);
        if (late_rsp) begin
            @(negedge clk);
            chk("late.still_fetch", {63'd0, req_valid}, 64'd1);
            chk("late.inst",        {32'd0, inst},      64'd0);
            rsp_valid = 1'b0;
        end
    endtask

    // One instruction: rd cycles of backpressure, wd extra cycles of response
    // latency, dd extra cycles before done. Starts and ends on a negedge.
    task automatic run_instr(input int rd, input int wd, input int dd,
                             input logic [63:0] target, input logic hlt);
        logic [31:0] word;
        word = $urandom;
        for (int k = 0; k <= rd; k++) begin
            chk("fetch.req",  {63'd0, req_valid},  64'd1);
            chk("fetch.addr", ifu_addr,            m_pc);
            chk("fetch.iv",   {63'd0, inst_valid}, 64'd0);
            req_ready = (k == rd);
            rsp_valid = (k != rd) && k[0];
            rsp_inst  = $urandom;
            exu_done  = 1'($urandom);
            halt      = 1'($urandom);
            dnpc      = {$urandom, $urandom};
            @(negedge clk);
        end
        for (int k = 0; k <= wd; k++) begin
            chk("wait.req", {63'd0, req_valid},  64'd0);
            chk("wait.iv",  {63'd0, inst_valid}, 64'd0);
            req_ready = 1'($urandom);
            rsp_valid = (k == wd);
            rsp_inst  = (k == wd) ? word : 32'($urandom);
            exu_done  = 1'($urandom);
            halt      = 1'($urandom);
            dnpc      = {$urandom, $urandom};
            @(negedge clk);
        end
        m_inst = word;
        for (int k = 0; k <= dd; k++) begin
            chk("exec.iv",   {63'd0, inst_valid}, 64'd1);
            chk("exec.inst", {32'd0, inst},       {32'd0, m_inst});
            chk("exec.pc",   pc,                  m_pc);
            chk("exec.req",  {63'd0, req_valid},  64'd0);
            req_ready = 1'($urandom);
            rsp_valid = 1'($urandom);
            rsp_inst  = $urandom;
            exu_done  = (k == dd);
            halt      = (k == dd) ? hlt : 1'b0;
            dnpc      = (k == dd) ? target : {$urandom, $urandom};
            @(negedge clk);
        end
        idle_inputs();
        if (hlt) begin
            m_cnt    = m_cnt + 64'd1;
            m_halted = 1'b1;
        end else if (target[1:0] != 2'b00) begin
            m_halted = 1'b1;
            m_fault  = 1'b1;
        end else begin
            m_pc  = target;
            m_cnt = m_cnt + 64'd1;
        end
        check_arch("retire");
        if (m_halted) begin
            for (int k = 0; k < 4; k++) begin
                req_ready = 1'b1;
                rsp_valid = 1'b1;
                rsp_inst  = $urandom;
                exu_done  = 1'b1;
                halt      = 1'($urandom);
                dnpc      = {$urandom, 32'($urandom) & 32'hffff_fffc};
                @(negedge clk);
                chk("halt.req", {63'd0, req_valid},  64'd0);
                chk("halt.iv",  {63'd0, inst_valid}, 64'd0);
                chk("halt.inst", {32'd0, inst},      {32'd0, m_inst});
                check_arch("halt");
            end
            idle_inputs();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] tgt;
        int          r;
        rst = 1'b1;
        idle_inputs();
        model_reset();

        do_reset(1'b0);

        // Straight-line code at minimum latency.
        for (int i = 0; i < 3; i++) run_instr(0, 0, 0, m_pc + 64'd4, 1'b0);
        chk("seq.cnt",  retire_cnt, 64'd3);
        chk("seq.addr", ifu_addr,   64'h8000_000c);

        run_instr(5, 0, 0, m_pc + 64'd4, 1'b0);

        run_instr(0, 1, 2, 64'h8000_0100, 1'b0);
        chk("branch.addr", ifu_addr,   64'h8000_0100);
        chk("branch.cnt",  retire_cnt, 64'd5);

        run_instr(0, 0, 0, m_pc + 64'd4, 1'b1);
        chk("ebreak.halted", {63'd0, halted}, 64'd1);

        do_reset(1'b0);
        run_instr(1, 1, 1, 64'h8000_0102, 1'b0);
        chk("misalign.fault", {63'd0, fault}, 64'd1);
        chk("misalign.cnt",   retire_cnt,     64'd0);

        do_reset(1'b0);
        run_instr(0, 0, 0, 64'h8000_0102, 1'b1);
        chk("both.fault", {63'd0, fault}, 64'd0);
        chk("both.cnt",   retire_cnt,     64'd1);

        // Reset while a fetch is outstanding, then a stale response.
        do_reset(1'b0);
        run_instr(0, 0, 0, m_pc + 64'd4, 1'b0);
        req_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("wreset.inwait", {63'd0, req_valid}, 64'd0);
        do_reset(1'b1);
        run_instr(0, 0, 0, m_pc + 64'd4, 1'b0);
        chk("wreset.pc", pc, RST_PC + 64'd4);

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                tgt = m_pc + 64'd4;
            end else if (r == 1) begin
                tgt = {$urandom, $urandom};
                if (tgt[1:0] == 2'b00) tgt[0] = 1'b1;
            end else if (r < 6) begin
                tgt = {$urandom, 32'($urandom) & 32'hffff_fffc};
            end else begin
                tgt = m_pc + 64'd4;
            end
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), tgt, r == 0);
            if (m_halted) do_reset(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
